// File: rtl/rlc_word_serializer_pkg.sv
// Shared constants and types for the run-length record serializer.
// Field widths default to the values used by the upstream run-length coder.
package rlc_word_serializer_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 107;
  localparam int DEF_NW = 11;

  localparam logic [3:0] MRK_NIBBLE = 4'hE;
  localparam logic       TAG_REC    = 1'b0;
  localparam logic       TAG_MRK    = 1'b1;

  localparam logic [1:0]  LAST_BEAT = 2'd3;
  localparam logic [10:0] CNT_MAX   = 11'd2047;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_MRK  = 2'd2
  } state_t;

endpackage

// File: rtl/rlc_word_serializer_if.sv
// 32-bit word stream leaving the serializer.
// A word transfers on a rising edge where out_valid && out_ready; once out_valid
// is raised it, out_data and out_last stay fixed until that transfer happens.
interface rlc_word_serializer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/rlc_rec_fifo.sv
// Circular record buffer: up to two entries written per cycle (slot 0 first),
// one entry popped per cycle, with level and free-entry counts.
module rlc_rec_fifo #(
  parameter int DEPTH = 16,
  parameter int EW    = 118
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic                   wr_en0,
  input  logic [EW-1:0]          wr_data0,
  input  logic                   wr_en1,
  input  logic [EW-1:0]          wr_data1,
  input  logic                   rd_en,
  output logic [EW-1:0]          head,
  output logic                   second_tag,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] free
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   n_push;

  // wr_en1 is only ever raised together with wr_en0
  assign n_push = (PW+1)'(wr_en0) + (PW+1)'(wr_en1);

  always_ff @(posedge clk) begin
    if (wr_en0) mem[wp] <= wr_data0;
    if (wr_en1) mem[wp + PW'(1)] <= wr_data1;
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + n_push[PW-1:0];
      rp    <= rp + PW'(rd_en);
      level <= level + n_push - (PW+1)'(rd_en);
    end
  end

  assign head       = mem[rp];
  assign second_tag = mem[rp + PW'(1)][EW-1];
  assign empty      = (level == '0);
  assign free       = DEPTH_L - level;

endmodule

// File: rtl/rlc_word_serializer.sv
// Buffers run-length records and end-of-block markers, then emits each record
// as four 32-bit words and each marker as one word flagged with out_last.
module rlc_word_serializer
  import rlc_word_serializer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int NW    = DEF_NW
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic                   in_wen,
  input  logic [AW-1:0]          in_waddr,
  input  logic [DW-1:0]          in_wdata,
  input  logic                   in_vaild,
  input  logic [NW-1:0]          in_dc,
  rlc_word_serializer_if.master  stream,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] fifo_level,
  output state_t                 dbg_state
);

  localparam int EW = DW + AW + 1;
  localparam int LW = $clog2(DEPTH) + 1;

  state_t        state, state_n;
  logic [1:0]    beat, beat_n;
  logic [10:0]   blk_cnt, cnt_inc, mrk_cnt;
  logic          rec_ok, mrk_ok, pop, second_tag, empty;
  logic [LW-1:0] free, free_eff;
  logic [EW-1:0] head, rec_ent, mrk_ent;
  logic [DW-1:0] mrk_pl, h_pl;
  logic [AW-1:0] h_addr;
  logic [31:0]   data_c;
  logic          valid_c, last_c;
  state_t        after_pop;

  // An entry popped this cycle frees its slot for a same-cycle push.
  assign free_eff = free + LW'(pop);

  always_comb begin
    rec_ok = 1'b0;
    mrk_ok = 1'b0;
    if (free_eff >= LW'(2)) begin
      rec_ok = in_wen;
      mrk_ok = in_vaild;
    end else if (free_eff == LW'(1)) begin
      mrk_ok = in_vaild;
      rec_ok = in_wen && !in_vaild;
    end
  end

  assign cnt_inc = (blk_cnt == CNT_MAX) ? blk_cnt : blk_cnt + 11'd1;
  assign mrk_cnt = rec_ok ? cnt_inc : blk_cnt;

  always_comb begin
    mrk_pl        = '0;
    mrk_pl[10:0]  = in_dc;
    mrk_pl[21:11] = mrk_cnt;
  end

  assign rec_ent = {TAG_REC, in_waddr, in_wdata};
  assign mrk_ent = {TAG_MRK, {AW{1'b0}}, mrk_pl};

  rlc_rec_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
    .clk        (clk),
    .srst_n     (srst_n),
    .wr_en0     (rec_ok || mrk_ok),
    .wr_data0   (rec_ok ? rec_ent : mrk_ent),
    .wr_en1     (rec_ok && mrk_ok),
    .wr_data1   (mrk_ent),
    .rd_en      (pop),
    .head       (head),
    .second_tag (second_tag),
    .empty      (empty),
    .level      (fifo_level),
    .free       (free)
  );

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      blk_cnt <= '0;
      ovf     <= 1'b0;
      state   <= ST_IDLE;
      beat    <= '0;
    end else begin
      if (mrk_ok)      blk_cnt <= '0;
      else if (rec_ok) blk_cnt <= cnt_inc;
      if ((in_wen && !rec_ok) || (in_vaild && !mrk_ok)) ovf <= 1'b1;
      state <= state_n;
      beat  <= beat_n;
    end
  end

  assign h_pl   = head[DW-1:0];
  assign h_addr = head[DW +: AW];

  // Choosing from the second entry lets the next item start without a bubble.
  assign after_pop = (fifo_level > LW'(1)) ? (second_tag ? ST_MRK : ST_REC) : ST_IDLE;

  always_comb begin
    state_n = state;
    beat_n  = beat;
    pop     = 1'b0;
    valid_c = 1'b0;
    last_c  = 1'b0;
    data_c  = '0;
    case (state)
      ST_IDLE: begin
        beat_n = '0;
        if (!empty) state_n = head[EW-1] ? ST_MRK : ST_REC;
      end
      ST_REC: begin
        valid_c = 1'b1;
        case (beat)
          2'd0:    data_c = h_pl[31:0];
          2'd1:    data_c = h_pl[63:32];
          2'd2:    data_c = h_pl[95:64];
          default: data_c = {h_addr[9:0], 11'b0, h_pl[106:96]};
        endcase
        if (stream.out_ready) begin
          if (beat == LAST_BEAT) begin
            pop     = 1'b1;
            beat_n  = '0;
            state_n = after_pop;
          end else begin
            beat_n = beat + 2'd1;
          end
        end
      end
      ST_MRK: begin
        valid_c = 1'b1;
        last_c  = 1'b1;
        data_c  = {MRK_NIBBLE, 6'b0, h_pl[21:11], h_pl[10:0]};
        if (stream.out_ready) begin
          pop     = 1'b1;
          state_n = after_pop;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign stream.out_data  = data_c;
  assign stream.out_valid = valid_c;
  assign stream.out_last  = last_c;
  assign dbg_state        = state;

endmodule

// File: tb/tb_rlc_word_serializer.sv
// Directed bench for rlc_word_serializer: table of block traffic plus
// hand-written backpressure, overflow, marker-priority and async-reset sequences.
module tb_rlc_word_serializer;
  import rlc_word_serializer_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          srst_n = 1'b0;
  logic          in_wen = 1'b0;
  logic          in_vaild = 1'b0;
  logic [9:0]    in_waddr = '0;
  logic [106:0]  in_wdata = '0;
  logic [10:0]   in_dc = '0;
  logic          ovf;
  logic [LW-1:0] fifo_level;
  state_t        dbg_state;

  rlc_word_serializer_if bus ();

  rlc_word_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .srst_n     (srst_n),
    .in_wen     (in_wen),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .in_vaild   (in_vaild),
    .in_dc      (in_dc),
    .stream     (bus.master),
    .ovf        (ovf),
    .fifo_level (fifo_level),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int run = 0;
  int max_run = 0;
  logic [32:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;
  logic [32:0] mon_w;

  typedef struct {
    logic            wen;
    logic [9:0]      addr;
    logic [106:0]    data;
    logic            vaild;
    logic [10:0]     dc;
    int              n;
    logic [4:0][32:0] exp;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the head of exp_q; stalled beats must hold.
  always @(negedge clk) begin
    if (!srst_n) begin
      prev_stall = 1'b0;
      run = 0;
    end else begin
      mon_w = {bus.out_last, bus.out_data};
      if (prev_stall) chk("hold", {30'b0, bus.out_valid, mon_w}, {30'b0, 1'b1, prev_word});
      if (bus.out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat actual=%0h expected=none", mon_w);
        end else begin
          chk("beat", {31'b0, mon_w}, {31'b0, exp_q.pop_front()});
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = mon_w;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [9:0] a, input logic [106:0] d,
                       input logic v, input logic [10:0] dc);
    in_wen = wen; in_waddr = a; in_wdata = d; in_vaild = v; in_dc = dc;
    cyc();
    in_wen = 1'b0; in_vaild = 1'b0;
  endtask

  task automatic send_pat(input int i, input bit queue_it);
    logic [106:0] d;
    d = {11'(i), 32'hA5A5_0000 + 32'(i), 32'(i * 3), 32'(i)};
    if (queue_it) begin
      exp_q.push_back({1'b0, 32'(i)});
      exp_q.push_back({1'b0, 32'(i * 3)});
      exp_q.push_back({1'b0, 32'hA5A5_0000 + 32'(i)});
      exp_q.push_back({1'b0, 10'(i), 11'b0, 11'(i)});
    end
    drive(1'b1, 10'(i), d, 1'b0, 11'h0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 600) begin
      cyc();
      k++;
    end
    chk(name, {32'(exp_q.size()), 31'b0, bus.out_valid}, 64'b0);
  endtask

  task automatic setv(input int i, input logic wen, input logic [9:0] a, input logic [106:0] d,
                      input logic v, input logic [10:0] dc, input int n,
                      input logic [32:0] e0, input logic [32:0] e1, input logic [32:0] e2,
                      input logic [32:0] e3, input logic [32:0] e4);
    vt[i].wen = wen; vt[i].addr = a; vt[i].data = d; vt[i].vaild = v; vt[i].dc = dc;
    vt[i].n = n;
    vt[i].exp[0] = e0; vt[i].exp[1] = e1; vt[i].exp[2] = e2; vt[i].exp[3] = e3; vt[i].exp[4] = e4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int k;
    setv(0, 1, 10'h155, 107'h1_2345_6789_ABCD_EF01_2345_6789, 0, 11'h0, 4,
         33'h0_2345_6789, 33'h0_ABCD_EF01, 33'h0_2345_6789, 33'h0_5540_0001, 33'h0);
    setv(1, 0, 10'h0, 107'h0, 0, 11'h0, 0, 33'h0, 33'h0, 33'h0, 33'h0, 33'h0);
    setv(2, 0, 10'h0, 107'h0, 1, 11'h7F0, 1, 33'h1_E000_0FF0, 33'h0, 33'h0, 33'h0, 33'h0);
    setv(3, 1, 10'h3FF, '1, 0, 11'h0, 4,
         33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFC0_07FF, 33'h0);
    setv(4, 1, 10'h000, {11'h400, 32'h0, 32'hFFFF_0000, 32'h1}, 0, 11'h0, 4,
         33'h0_0000_0001, 33'h0_FFFF_0000, 33'h0_0000_0000, 33'h0_0000_0400, 33'h0);
    setv(5, 1, 10'h2AA, {11'h2AA, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_BABE}, 1, 11'd5, 5,
         33'h0_CAFE_BABE, 33'h0_0BAD_F00D, 33'h0_DEAD_BEEF, 33'h0_AA80_02AA, 33'h1_E000_1805);
    setv(6, 0, 10'h0, 107'h0, 1, 11'h7FF, 1, 33'h1_E000_07FF, 33'h0, 33'h0, 33'h0, 33'h0);

    bus.out_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_last", {63'b0, bus.out_last}, 64'd0);
    chk("rst_data", {32'b0, bus.out_data}, 64'd0);
    chk("rst_ovf", {63'b0, ovf}, 64'd0);
    chk("rst_level", {59'b0, fifo_level}, 64'd0);
    chk("rst_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
    srst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc();

    // Table: single block, marker after a gap, record+marker together, empty block.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vt[i].n; j++) exp_q.push_back(vt[i].exp[j]);
      drive(vt[i].wen, vt[i].addr, vt[i].data, vt[i].vaild, vt[i].dc);
    end
    drain("vectors_drain");
    chk("vectors_level", {59'b0, fifo_level}, 64'd0);

    // Back-to-back: three records then a marker, no gaps in the output.
    max_run = 0;
    for (int i = 1; i <= 3; i++) send_pat(i, 1'b1);
    exp_q.push_back(33'h1_E000_180A);
    drive(1'b0, 10'h0, 107'h0, 1'b1, 11'h00A);
    drain("b2b_drain");
    chk("b2b_run", 64'(max_run), 64'd13);

    // Backpressure: ready 1,0,0,1 while a record is on the bus.
    bus.out_ready = 1'b0;
    a0 = n_acc;
    exp_q.push_back(33'h0_1111_1111);
    exp_q.push_back(33'h0_2222_2222);
    exp_q.push_back(33'h0_3333_3333);
    exp_q.push_back(33'h0_3C00_07AB);
    drive(1'b1, 10'h0F0, {11'h7AB, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0, 11'h0);
    k = 0;
    while (!bus.out_valid && k < 20) begin cyc(); k++; end
    chk("bp_valid", {63'b0, bus.out_valid}, 64'd1);
    bus.out_ready = 1'b1; cyc();
    bus.out_ready = 1'b0; cyc(); cyc();
    bus.out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_accepts", 64'(n_acc - a0), 64'd4);

    // Overflow: 17 records with no drain; the 17th is lost.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_pat(i + 32, i < 16);
    cyc();
    chk("ovf_level", {59'b0, fifo_level}, 64'd16);
    chk("ovf_flag", {63'b0, ovf}, 64'd1);
    bus.out_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", {63'b0, ovf}, 64'd1);
    chk("ovf_level0", {59'b0, fifo_level}, 64'd0);

    // Async reset in the middle of beat 2.
    exp_q.push_back(33'h0_0000_000A);
    exp_q.push_back(33'h0_0000_000B);
    drive(1'b1, 10'h0AA, {11'h055, 32'hC, 32'hB, 32'hA}, 1'b0, 11'h0);
    k = 0;
    while (!bus.out_valid && k < 20) begin cyc(); k++; end
    cyc(); cyc();
    chk("mid_b2", {32'b0, bus.out_data}, 64'h0000_000C);
    #1 srst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("mid_rst_data", {32'b0, bus.out_data}, 64'd0);
    chk("mid_rst_level", {59'b0, fifo_level}, 64'd0);
    chk("mid_rst_ovf", {63'b0, ovf}, 64'd0);
    cyc(); cyc();
    srst_n = 1'b1;
    cyc();
    send_pat(7, 1'b1);
    drain("post_rst_drain");

    // One free slot: marker wins over the same-cycle record; count excludes it.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_pat(i + 64, 1'b1);
    exp_q.push_back(33'h1_E000_8001);
    drive(1'b1, 10'h3C3, 107'h5, 1'b1, 11'h001);
    cyc();
    chk("prio_level", {59'b0, fifo_level}, 64'd16);
    chk("prio_ovf", {63'b0, ovf}, 64'd1);
    bus.out_ready = 1'b1;
    drain("prio_drain");
    exp_q.push_back(33'h1_E000_0002);
    drive(1'b0, 10'h0, 107'h0, 1'b1, 11'h002);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
